// File: rtl/hwpe_ctrl_ctx_sched_pkg.sv
// Shared types for the HWPE job-context scheduler and its register file.
package hwpe_ctrl_package;

   // Widest context index supported (N_CONTEXT up to 4).
   localparam int unsigned CTX_MAX_CW = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      START   = 2'd1,
      RUNNING = 2'd2,
      DONE    = 2'd3
   } ctx_sched_state_t;

   // Status bundle exported towards the register file.
   typedef struct packed {
      logic [CTX_MAX_CW-1:0] pointer_context;
      logic [CTX_MAX_CW-1:0] running_context;
      logic                  is_critical;
      logic                  full_context;
      logic                  true_done;
   } ctx_sched_flags_t;

endpackage

// File: rtl/hwpe_ctrl_ctx_sched.sv
// Job-context scheduler: offloaders acquire/commit contexts in a ring,
// the engine executes committed jobs strictly in commit order.
module hwpe_ctrl_ctx_sched
   import hwpe_ctrl_package::*;
#(
   parameter int unsigned N_CONTEXT = 2,
   localparam int unsigned CW = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1,
   localparam int unsigned NW = $clog2(N_CONTEXT + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_i,
   input  logic          acquire_i,
   input  logic          trigger_i,
   input  logic          done_i,
   output logic          start_o,
   output logic          true_done_o,
   output logic [CW-1:0] pointer_context_o,
   output logic [CW-1:0] running_context_o,
   output logic          is_critical_o,
   output logic          full_context_o,
   output logic          busy_o,
   output logic [NW-1:0] n_pending_o
);

   localparam logic [CW-1:0] LAST_CTX = CW'(N_CONTEXT - 1);
   localparam logic [NW-1:0] N_FULL   = NW'(N_CONTEXT);

   ctx_sched_state_t state_q, state_d;
   logic [CW-1:0]    ptr_q, ptr_d;
   logic [CW-1:0]    run_q, run_d;
   logic [NW-1:0]    pend_q, pend_d;
   logic             crit_q, crit_d;
   logic             acq_ok, trig_ok, retire;

   // Next-state logic for the FSM, both ring pointers, pending count and lock.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      run_d       = run_q;
      pend_d      = pend_q;
      crit_d      = crit_q;
      start_o     = 1'b0;
      true_done_o = 1'b0;
      retire      = 1'b0;

      // acquire and trigger are mutually exclusive through crit_q
      acq_ok  = acquire_i & ~crit_q & (pend_q < N_FULL);
      trig_ok = trigger_i & crit_q;

      case (state_q)
         IDLE:    if (pend_q != '0) state_d = START;
         START: begin
            start_o = 1'b1;
            state_d = RUNNING;
         end
         RUNNING: if (done_i) state_d = DONE;
         DONE: begin
            true_done_o = 1'b1;
            retire      = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (trig_ok)     crit_d = 1'b0;
      else if (acq_ok) crit_d = 1'b1;

      if (trig_ok) ptr_d = (ptr_q == LAST_CTX) ? '0 : ptr_q + CW'(1);
      if (retire)  run_d = (run_q == LAST_CTX) ? '0 : run_q + CW'(1);

      // commit and retire on the same edge cancel out
      case ({trig_ok, retire})
         2'b10:   pend_d = pend_q + NW'(1);
         2'b01:   pend_d = pend_q - NW'(1);
         default: pend_d = pend_q;
      endcase

      if (clear_i) begin
         state_d = IDLE;
         ptr_d   = '0;
         run_d   = '0;
         pend_d  = '0;
         crit_d  = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         run_q   <= '0;
         pend_q  <= '0;
         crit_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         run_q   <= run_d;
         pend_q  <= pend_d;
         crit_q  <= crit_d;
      end
   end

   // Status outputs derived from registered state.
   always_comb begin
      pointer_context_o = ptr_q;
      running_context_o = run_q;
      is_critical_o     = crit_q;
      n_pending_o       = pend_q;
      full_context_o    = ((pend_q + NW'(crit_q)) == N_FULL);
      busy_o            = (state_q != IDLE);
   end

endmodule

// File: tb/tb_hwpe_ctrl_ctx_sched.sv
// Bench for hwpe_ctrl_ctx_sched: cycle table for N_CONTEXT=2, plus
// hand-written clear (N_CONTEXT=4) and asynchronous-reset sequences.
module tb_hwpe_ctrl_ctx_sched;

   typedef struct packed {
      logic       st;
      logic       td;
      logic [1:0] ptr;
      logic [1:0] run;
      logic       crit;
      logic       full;
      logic       busy;
      logic [2:0] np;
   } out_t;

   typedef struct packed {
      logic a;
      logic t;
      logic d;
      logic c;
      out_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // N_CONTEXT = 2 instance
   logic       clr2, acq2, trg2, dn2;
   logic       st2, td2, crit2, full2, busy2;
   logic [0:0] ptr2, run2;
   logic [1:0] np2;

   // N_CONTEXT = 4 instance
   logic       clr4, acq4, trg4, dn4;
   logic       st4, td4, crit4, full4, busy4;
   logic [1:0] ptr4, run4;
   logic [2:0] np4;

   hwpe_ctrl_ctx_sched #(.N_CONTEXT(2)) u_dut2 (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .clear_i          (clr2),
      .acquire_i        (acq2),
      .trigger_i        (trg2),
      .done_i           (dn2),
      .start_o          (st2),
      .true_done_o      (td2),
      .pointer_context_o(ptr2),
      .running_context_o(run2),
      .is_critical_o    (crit2),
      .full_context_o   (full2),
      .busy_o           (busy2),
      .n_pending_o      (np2)
   );

   hwpe_ctrl_ctx_sched #(.N_CONTEXT(4)) u_dut4 (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .clear_i          (clr4),
      .acquire_i        (acq4),
      .trigger_i        (trg4),
      .done_i           (dn4),
      .start_o          (st4),
      .true_done_o      (td4),
      .pointer_context_o(ptr4),
      .running_context_o(run4),
      .is_critical_o    (crit4),
      .full_context_o   (full4),
      .busy_o           (busy4),
      .n_pending_o      (np4)
   );

   int   n_pass  = 0;
   int   n_total = 0;
   vec_t vecs[$];
   out_t sb[$];

   function automatic out_t act2();
      return '{st2, td2, {1'b0, ptr2}, {1'b0, run2}, crit2, full2, busy2, {1'b0, np2}};
   endfunction

   function automatic out_t act4();
      return '{st4, td4, ptr4, run4, crit4, full4, busy4, np4};
   endfunction

   function automatic out_t mo(input logic st, input logic td, input int ptr, input int run,
                               input logic crit, input logic full, input logic busy, input int np);
      return '{st, td, 2'(ptr), 2'(run), crit, full, busy, 3'(np)};
   endfunction

   task automatic chk(input string tag, input string f, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s.%s: got %0d, expected %0d", tag, f, act, exp);
   endtask

   task automatic cmp(input string tag, input out_t act, input out_t exp);
      chk(tag, "start_o",           int'(act.st),   int'(exp.st));
      chk(tag, "true_done_o",       int'(act.td),   int'(exp.td));
      chk(tag, "pointer_context_o", int'(act.ptr),  int'(exp.ptr));
      chk(tag, "running_context_o", int'(act.run),  int'(exp.run));
      chk(tag, "is_critical_o",     int'(act.crit), int'(exp.crit));
      chk(tag, "full_context_o",    int'(act.full), int'(exp.full));
      chk(tag, "busy_o",            int'(act.busy), int'(exp.busy));
      chk(tag, "n_pending_o",       int'(act.np),   int'(exp.np));
   endtask

   task automatic add(input logic a, input logic t, input logic d, input logic c, input out_t e);
      vecs.push_back('{a, t, d, c, e});
   endtask

   task automatic drive4(input logic a, input logic t, input logic d, input logic c);
      @(negedge clk);
      acq4 = a; trg4 = t; dn4 = d; clr4 = c;
      @(posedge clk);
      #1;
   endtask

   out_t e;

   initial begin
      rst_n = 1'b0;
      {clr2, acq2, trg2, dn2} = '0;
      {clr4, acq4, trg4, dn4} = '0;

      // Expected outputs after each edge, N_CONTEXT=2.
      //   a  t  d  c      st td ptr run crit full busy np
      add(0, 0, 0, 0, mo(0, 0, 0, 0, 0, 0, 0, 0)); // 0 no start after reset
      add(0, 0, 1, 0, mo(0, 0, 0, 0, 0, 0, 0, 0)); // 1 done in IDLE ignored
      add(0, 1, 0, 0, mo(0, 0, 0, 0, 0, 0, 0, 0)); // 2 trigger w/o acquire ignored
      add(1, 0, 0, 0, mo(0, 0, 0, 0, 1, 0, 0, 0)); // 3 acquire
      add(0, 1, 0, 0, mo(0, 0, 1, 0, 0, 0, 0, 1)); // 4 trigger at edge 5
      add(0, 0, 0, 0, mo(1, 0, 1, 0, 0, 0, 1, 1)); // 5 START
      add(0, 0, 0, 0, mo(0, 0, 1, 0, 0, 0, 1, 1)); // 6 RUNNING
      add(1, 0, 0, 0, mo(0, 0, 1, 0, 1, 1, 1, 1)); // 7 second acquire -> full
      add(0, 1, 0, 0, mo(0, 0, 0, 0, 0, 1, 1, 2)); // 8 second trigger, ptr wraps
      add(1, 0, 0, 0, mo(0, 0, 0, 0, 0, 1, 1, 2)); // 9 third acquire ignored
      add(0, 0, 1, 0, mo(0, 1, 0, 0, 0, 1, 1, 2)); // 10 done -> DONE
      add(0, 0, 0, 0, mo(0, 0, 0, 1, 0, 0, 0, 1)); // 11 retire
      add(0, 0, 0, 0, mo(1, 0, 0, 1, 0, 0, 1, 1)); // 12 second START
      add(0, 0, 1, 0, mo(0, 0, 0, 1, 0, 0, 1, 1)); // 13 done in START ignored
      add(1, 0, 0, 0, mo(0, 0, 0, 1, 1, 1, 1, 1)); // 14 acquire while RUNNING
      add(0, 0, 1, 0, mo(0, 1, 0, 1, 1, 1, 1, 1)); // 15 DONE
      add(0, 1, 0, 0, mo(0, 0, 1, 0, 0, 0, 0, 1)); // 16 trigger on DONE->IDLE
      add(0, 0, 0, 0, mo(1, 0, 1, 0, 0, 0, 1, 1)); // 17 START ctx 0
      add(0, 0, 0, 0, mo(0, 0, 1, 0, 0, 0, 1, 1)); // 18 RUNNING
      add(1, 0, 0, 0, mo(0, 0, 1, 0, 1, 1, 1, 1)); // 19 acquire
      add(0, 0, 1, 1, mo(0, 0, 0, 0, 0, 0, 0, 0)); // 20 clear beats done
      add(0, 0, 0, 0, mo(0, 0, 0, 0, 0, 0, 0, 0)); // 21 stays idle

      repeat (2) @(posedge clk);
      #1;
      cmp("reset2", act2(), mo(0, 0, 0, 0, 0, 0, 0, 0));
      cmp("reset4", act4(), mo(0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         if (i != 0) @(negedge clk);
         acq2 = vecs[i].a; trg2 = vecs[i].t; dn2 = vecs[i].d; clr2 = vecs[i].c;
         sb.push_back(vecs[i].exp);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            chk($sformatf("row%0d", i), "scoreboard_empty", 1, 0);
         end else begin
            e = sb.pop_front();
            cmp($sformatf("row%0d", i), act2(), e);
         end
      end
      @(negedge clk);
      {clr2, acq2, trg2, dn2} = '0;

      // N_CONTEXT=4: clear mid-job with two pending jobs and a held context.
      drive4(1, 0, 0, 0);
      drive4(0, 1, 0, 0);
      cmp("n4_commit1", act4(), mo(0, 0, 1, 0, 0, 0, 0, 1));
      drive4(1, 0, 0, 0);
      cmp("n4_start",   act4(), mo(1, 0, 1, 0, 1, 0, 1, 1));
      drive4(0, 1, 0, 0);
      drive4(1, 0, 0, 0);
      cmp("n4_loaded",  act4(), mo(0, 0, 2, 0, 1, 0, 1, 2));
      drive4(0, 0, 1, 1);
      cmp("n4_clear",   act4(), mo(0, 0, 0, 0, 0, 0, 0, 0));
      drive4(0, 0, 0, 0);
      cmp("n4_after",   act4(), mo(0, 0, 0, 0, 0, 0, 0, 0));

      // Asynchronous reset between edges while a job is starting.
      @(negedge clk); acq2 = 1'b1;
      @(negedge clk); acq2 = 1'b0; trg2 = 1'b1;
      @(negedge clk); trg2 = 1'b0;
      @(posedge clk);
      #1;
      cmp("pre_arst", act2(), mo(1, 0, 1, 0, 0, 0, 1, 1));
      #2;
      rst_n = 1'b0;
      #1;
      cmp("arst", act2(), mo(0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cmp("post_arst", act2(), mo(0, 0, 0, 0, 0, 0, 0, 0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
